vga_data_controller: RTL and testbench

Bridge between the VGA timing generator and the shared SRAM bus. It prefetches 32-bit frame-buffer words from SRAM ahead of the beam and presents one word per 32 active pixels on data_to_VGA, where the pixel shifter consumes it MSB first at 1 bit per pixel. It sits between the VGA sync/timing block, which supplies h_count and VGA_state, and the SRAM arbiter.

---
 rtl/vga_pkg.sv | 42 ++++
 rtl/vga_fetch_fsm.sv | 79 +++++++
 rtl/vga_data_controller.sv | 103 ++++++++++
 tb/tb_vga_data_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and horizontal timing constants for the VGA data path.
package vga_pkg;

    // Line phase as reported by the sync/timing block
    typedef enum logic [1:0] {
        SYNC        = 2'd0,
        BACK_PORCH  = 2'd1,
        ACTIVE      = 2'd2,
        FRONT_PORCH = 2'd3
    } vga_state_t;

    // Request FSM states of the SRAM fetch engine
    typedef enum logic {
        FETCH_IDLE    = 1'b0,
        FETCH_PENDING = 1'b1
    } fetch_state_t;

    localparam int unsigned H_SYNC          = 32'd96;
    localparam int unsigned H_BACK          = 32'd48;
    localparam int unsigned H_ACTIVE        = 32'd640;
    localparam int unsigned H_FRONT         = 32'd16;
    localparam int unsigned H_TOTAL         = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned WORDS_PER_LINE  = 32'd20;
    localparam int unsigned PIXELS_PER_WORD = 32'd32;

    // Overwrite only the byte lanes flagged valid by the SRAM
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                result[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/vga_fetch_fsm.sv
// SRAM read request engine: raises read at an issue point and holds the
// request stable until the first data_en strobe, re-targeting on a new issue.
module vga_fetch_fsm
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic        issue_i,
    input  logic [31:0] issue_addr_i,
    input  logic        data_en_i,
    output logic        read_o,
    output logic [31:0] sram_address_o,
    output logic [3:0]  byte_select_o,
    output logic        pending_o
);

    fetch_state_t state_q, state_d;
    logic         read_q, read_d;
    logic [31:0]  addr_q, addr_d;
    logic [3:0]   bse_q, bse_d;

    // Next-state and request outputs; a fresh issue always wins over completion
    always_comb begin
        state_d = state_q;
        read_d  = read_q;
        addr_d  = addr_q;
        bse_d   = bse_q;
        case (state_q)
            FETCH_IDLE: begin
                if (issue_i) begin
                    state_d = FETCH_PENDING;
                    read_d  = 1'b1;
                    addr_d  = issue_addr_i;
                    bse_d   = 4'hF;
                end else begin
                    state_d = FETCH_IDLE;
                end
            end
            FETCH_PENDING: begin
                if (issue_i) begin
                    addr_d  = issue_addr_i;
                    state_d = FETCH_PENDING;
                end else if (data_en_i) begin
                    state_d = FETCH_IDLE;
                    read_d  = 1'b0;
                    bse_d   = 4'h0;
                end else begin
                    state_d = FETCH_PENDING;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
                read_d  = 1'b0;
                bse_d   = 4'h0;
            end
        endcase
    end

    // Request registers with synchronous reset that aborts any read in flight
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q <= FETCH_IDLE;
            read_q  <= 1'b0;
            addr_q  <= 32'd0;
            bse_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            bse_q   <= bse_d;
        end
    end

    assign read_o         = read_q;
    assign sram_address_o = addr_q;
    assign byte_select_o  = bse_q;
    assign pending_o      = (state_q == FETCH_PENDING);

endmodule

// File: rtl/vga_data_controller.sv
// Frame-buffer prefetch bridge: fetches one word per 32 pixels ahead of the
// beam and hands it to the pixel shifter at each word boundary.
module vga_data_controller #(
    parameter int unsigned H_ACTIVE_START = 32'd144,
    parameter int unsigned WORDS_PER_LINE = vga_pkg::WORDS_PER_LINE,
    parameter int unsigned PREFETCH       = 32'd16,
    parameter int unsigned FRAME_WORDS    = 32'd9600
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] VGA_request_address,
    input  logic [31:0] data_from_SRAM,
    input  logic [9:0]  h_count,
    input  logic [1:0]  VGA_state,
    input  logic        data_en,
    input  logic [3:0]  byte_select_in,
    output logic [3:0]  byte_select_out,
    output logic        read,
    output logic [31:0] data_to_VGA,
    output logic [31:0] SRAM_address
);
    import vga_pkg::*;

    localparam int unsigned ISSUE_FIRST = H_ACTIVE_START - PREFETCH;
    localparam int unsigned LINE_SPAN   = PIXELS_PER_WORD * WORDS_PER_LINE;

    logic [31:0] h_wide_s, issue_rel_s, load_rel_s, issue_addr_s;
    logic        issue_hit_s, load_hit_s, last_load_s, active_s;
    logic        pending_s, capture_s;

    logic [31:0] buf_q, buf_d;
    logic [31:0] dvga_q, dvga_d;
    logic [31:0] word_offset_q, word_offset_d;

    assign h_wide_s     = 32'(h_count);
    assign active_s     = (vga_state_t'(VGA_state) == ACTIVE);
    assign issue_rel_s  = h_wide_s - ISSUE_FIRST;
    assign issue_hit_s  = (h_wide_s >= ISSUE_FIRST) && (h_wide_s < ISSUE_FIRST + LINE_SPAN)
                          && (issue_rel_s[4:0] == 5'd0);
    assign issue_addr_s = VGA_request_address + word_offset_q + (issue_rel_s >> 5);
    assign load_rel_s   = h_wide_s - H_ACTIVE_START;
    assign load_hit_s   = active_s && (h_wide_s >= H_ACTIVE_START)
                          && (h_wide_s < H_ACTIVE_START + LINE_SPAN)
                          && (load_rel_s[4:0] == 5'd0);
    assign last_load_s  = load_hit_s && ((load_rel_s >> 5) == WORDS_PER_LINE - 32'd1);
    assign capture_s    = pending_s && data_en;

    vga_fetch_fsm u_fetch (
        .clk            (clk),
        .nrst           (nrst),
        .issue_i        (issue_hit_s),
        .issue_addr_i   (issue_addr_s),
        .data_en_i      (data_en),
        .read_o         (read),
        .sram_address_o (SRAM_address),
        .byte_select_o  (byte_select_out),
        .pending_o      (pending_s)
    );

    // Buffer capture, pixel-word load/blanking and per-line frame offset advance
    always_comb begin
        buf_d         = buf_q;
        dvga_d        = dvga_q;
        word_offset_d = word_offset_q;
        if (capture_s) begin
            buf_d = merge_lanes(buf_q, data_from_SRAM, byte_select_in);
        end else begin
            buf_d = buf_q;
        end
        if (load_hit_s) begin
            dvga_d = buf_q;
        end else if (!active_s) begin
            dvga_d = 32'd0;
        end else begin
            dvga_d = dvga_q;
        end
        if (last_load_s) begin
            if (word_offset_q + WORDS_PER_LINE >= FRAME_WORDS) begin
                word_offset_d = 32'd0;
            end else begin
                word_offset_d = word_offset_q + WORDS_PER_LINE;
            end
        end else begin
            word_offset_d = word_offset_q;
        end
    end

    // Data-path registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (nrst) begin
            buf_q         <= 32'd0;
            dvga_q        <= 32'd0;
            word_offset_q <= 32'd0;
        end else begin
            buf_q         <= buf_d;
            dvga_q        <= dvga_d;
            word_offset_q <= word_offset_d;
        end
    end

    assign data_to_VGA = dvga_q;

endmodule

// File: tb/tb_vga_data_controller.sv
// Scoreboard bench for vga_data_controller: randomized SRAM latency and byte
// lanes, expected addresses and pixel words produced by a line-level model.
module tb_vga_data_controller;

    logic        clk = 1'b0;
    logic        nrst;
    logic [31:0] base;
    logic [31:0] data_from_SRAM;
    logic [9:0]  h_count;
    logic [1:0]  VGA_state;
    logic        data_en;
    logic [3:0]  byte_select_in;
    logic [3:0]  byte_select_out;
    logic        read;
    logic [31:0] data_to_VGA;
    logic [31:0] SRAM_address;

    vga_data_controller #(
        .H_ACTIVE_START (144),
        .WORDS_PER_LINE (20),
        .PREFETCH       (16),
        .FRAME_WORDS    (40)
    ) dut (
        .clk                 (clk),
        .nrst                (nrst),
        .VGA_request_address (base),
        .data_from_SRAM      (data_from_SRAM),
        .h_count             (h_count),
        .VGA_state           (VGA_state),
        .data_en             (data_en),
        .byte_select_in      (byte_select_in),
        .byte_select_out     (byte_select_out),
        .read                (read),
        .data_to_VGA         (data_to_VGA),
        .SRAM_address        (SRAM_address)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] mem [0:63];
    logic [31:0] pat [0:3] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h6AAA_5556, 32'h5555_5555};
    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_pix_q [$];
    int          cfg_delay_q [$];
    logic [3:0]  cfg_mask_q [$];
    bit          mon_en = 1'b0;
    bit          resp_en = 1'b0;
    logic [31:0] model_buf = 32'd0;
    int          model_off = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] m);
        logic [31:0] mask32;
        mask32 = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        return (old_w & ~mask32) | (new_w & mask32);
    endfunction

    function automatic logic [1:0] state_for(input int h, input bit active_line);
        if (h < 96) return 2'd0;
        else if (h < 144) return 2'd1;
        else if (h < 784 && active_line) return 2'd2;
        else return 2'd3;
    endfunction

    // One line of expectations: 20 fetches at base+offset+k; each active line shows them in order
    task automatic plan_line(input bit active_line, input int ln);
        logic [31:0] a;
        int          d;
        logic [3:0]  m;
        for (int k = 0; k < 20; k++) begin
            a = base + 32'(model_off) + 32'(k);
            if (ln == 1) begin
                d = 1; m = 4'b1111;
            end else if (ln == 2) begin
                d = 10; m = (k % 2 == 0) ? 4'b0011 : 4'b1111;
            end else begin
                d = $urandom_range(0, 10);
                m = ($urandom_range(0, 3) == 0) ? 4'b0011 : 4'b1111;
            end
            exp_addr_q.push_back(a);
            cfg_delay_q.push_back(d);
            cfg_mask_q.push_back(m);
            model_buf = lane_merge(model_buf, mem[a[5:0]], m);
            if (active_line) exp_pix_q.push_back(model_buf);
        end
        if (active_line) model_off = (model_off + 20) % 40;
    endtask

    // SRAM responder: answers each new request after a configured latency
    initial begin : responder
        logic       prev_rd;
        logic       cur_rd;
        int         d;
        logic [3:0] m;
        logic [31:0] a;
        prev_rd = 1'b0;
        data_en = 1'b0;
        byte_select_in = 4'h0;
        data_from_SRAM = 32'd0;
        forever begin
            @(negedge clk);
            cur_rd = read;
            if (resp_en && cur_rd && !prev_rd) begin
                prev_rd = cur_rd;
                d = (cfg_delay_q.size() > 0) ? cfg_delay_q.pop_front() : 0;
                m = (cfg_mask_q.size() > 0) ? cfg_mask_q.pop_front() : 4'hF;
                if (d == 0) begin
                    #2;
                end else begin
                    repeat (d) @(posedge clk);
                    #1;
                end
                a = SRAM_address;
                data_from_SRAM = mem[a[5:0]];
                byte_select_in = m;
                data_en = 1'b1;
                @(posedge clk);
                #1;
                data_en = 1'b0;
                byte_select_in = 4'($urandom);
                data_from_SRAM = $urandom;
            end else begin
                prev_rd = cur_rd;
            end
        end
    end

    // Monitor: pops expected request addresses and pixel words as the DUT presents them
    initial begin : monitor
        logic        prev_read;
        logic [9:0]  prev_h;
        logic [1:0]  prev_st;
        logic [31:0] cur_addr;
        int          ph;
        prev_read = 1'b0;
        prev_h = 10'd0;
        prev_st = 2'd0;
        cur_addr = 32'd0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (read && !prev_read) begin
                    if (exp_addr_q.size() == 0) begin
                        n_vec++; n_fail++;
                        $display("FAIL unexpected_read: got addr %h expected no request", SRAM_address);
                    end else begin
                        cur_addr = exp_addr_q.pop_front();
                        check32("req_addr", SRAM_address, cur_addr);
                    end
                    check32("req_bse", 32'(byte_select_out), 32'hF);
                end else if (read) begin
                    check32("hold_addr", SRAM_address, cur_addr);
                    check32("hold_bse", 32'(byte_select_out), 32'hF);
                end else begin
                    check32("idle_bse", 32'(byte_select_out), 32'h0);
                end
                ph = int'(prev_h);
                if (prev_st == 2'd2 && ph >= 144 && ph < 784 && (ph - 144) % 32 == 0) begin
                    if (exp_pix_q.size() == 0) begin
                        n_vec++; n_fail++;
                        $display("FAIL unexpected_load: got %h expected no load", data_to_VGA);
                    end else begin
                        check32("pix_word", data_to_VGA, exp_pix_q.pop_front());
                    end
                end else if (prev_st != 2'd2) begin
                    check32("blank_pix", data_to_VGA, 32'd0);
                end
            end
            prev_read = read;
            prev_h = h_count;
            prev_st = VGA_state;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        bit act;
        nrst = 1'b1;
        h_count = 10'd0;
        VGA_state = 2'd0;
        base = 32'd0;
        for (int i = 0; i < 64; i++) mem[i] = (i < 20) ? pat[i % 4] : $urandom;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check32("rst_read", 32'(read), 32'd0);
        check32("rst_bse", 32'(byte_select_out), 32'd0);
        check32("rst_addr", SRAM_address, 32'd0);
        check32("rst_pix", data_to_VGA, 32'd0);
        @(posedge clk);
        #1;
        nrst = 1'b0;
        mon_en = 1'b1;
        resp_en = 1'b1;

        for (int ln = 0; ln < 6; ln++) begin
            act = (ln == 1 || ln == 2 || ln == 3 || ln == 5);
            if (ln == 4) base = 32'd100 + 32'($urandom_range(0, 20));
            plan_line(act, ln);
            for (int h = 0; h < 800; h++) begin
                h_count = 10'(h);
                VGA_state = state_for(h, act);
                @(posedge clk);
                #1;
            end
        end
        check32("addr_q_left", 32'(exp_addr_q.size()), 32'd0);
        check32("pix_q_left", 32'(exp_pix_q.size()), 32'd0);

        // Unanswered fetch: stale load, re-target on next issue, then reset abort
        mon_en = 1'b0;
        resp_en = 1'b0;
        for (int h = 0; h < 166; h++) begin
            h_count = 10'(h);
            VGA_state = state_for(h, 1'b1);
            @(posedge clk);
            #1;
            if (h == 150) begin
                check32("pend_read", 32'(read), 32'd1);
                check32("pend_addr", SRAM_address, base + 32'(model_off));
                check32("stale_pix", data_to_VGA, model_buf);
            end
        end
        check32("retarget_read", 32'(read), 32'd1);
        check32("retarget_addr", SRAM_address, base + 32'(model_off) + 32'd1);
        check32("retarget_bse", 32'(byte_select_out), 32'hF);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        check32("abort_read", 32'(read), 32'd0);
        check32("abort_pix", data_to_VGA, 32'd0);
        check32("abort_addr", SRAM_address, 32'd0);
        check32("abort_bse", 32'(byte_select_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
